// File: rtl/cntry_car_detect.sv
// Country-road vehicle detector: debounces arrival/departure loops,
// counts queued vehicles and drives the registered car-waiting flag x.
//
// Ports:
//   clock      system clock, all state updates on posedge
//   clear      synchronous active-high reset, priority over all updates
//   arr_raw    raw arrival-loop level (1 = vehicle over loop)
//   dep_raw    raw departure-loop level (1 = vehicle over loop)
//   x          1 = car waiting (queue non-empty or hold-over running)
//   car_count  current queue length, saturates at 2^CNT_W-1
//   ovf        sticky: an arrival was dropped at saturation
module cntry_car_detect #(
    parameter int DEB_CYCLES  = 4,
    parameter int CNT_W       = 4,
    parameter int HOLD_CYCLES = 3
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             arr_raw,
    input  logic             dep_raw,
    output logic             x,
    output logic [CNT_W-1:0] car_count,
    output logic             ovf
);

    localparam int SC_W = $clog2(DEB_CYCLES + 1);
    localparam int HD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    localparam logic [SC_W-1:0]  SC_LAST = SC_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [HD_W-1:0]  HD_LOAD = HD_W'(HOLD_CYCLES);

    logic            arr_f;
    logic            dep_f;
    logic [SC_W-1:0] arr_sc;
    logic [SC_W-1:0] dep_sc;

    logic arr_flip;
    logic dep_flip;
    logic arr_evt;
    logic dep_evt;

    logic [CNT_W-1:0] cnt_n;
    logic             ovf_n;
    logic [HD_W-1:0]  hold;
    logic [HD_W-1:0]  hold_n;

    // A flip happens on the DEB_CYCLES-th consecutive mismatching sample.
    assign arr_flip = (arr_raw != arr_f) && (arr_sc == SC_LAST);
    assign dep_flip = (dep_raw != dep_f) && (dep_sc == SC_LAST);

    // Only the rising flip of a filter marks a vehicle event.
    assign arr_evt = arr_flip & ~arr_f;
    assign dep_evt = dep_flip & ~dep_f;

    always_comb begin
        cnt_n = car_count;
        ovf_n = ovf;
        if (arr_evt && !dep_evt) begin
            if (car_count != CNT_MAX) begin
                cnt_n = car_count + CNT_W'(1);
            end else begin
                ovf_n = 1'b1;
            end
        end else if (dep_evt && !arr_evt) begin
            if (car_count != '0) begin
                cnt_n = car_count - CNT_W'(1);
            end
        end
    end

    // Hold-over restarts only on the nonzero-to-zero transition of
    // the queue; a new arrival cancels any hold that is running.
    always_comb begin
        hold_n = '0;
        if (cnt_n != '0) begin
            hold_n = '0;
        end else if (car_count != '0) begin
            hold_n = HD_LOAD;
        end else if (hold != '0) begin
            hold_n = hold - HD_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            arr_f     <= 1'b0;
            dep_f     <= 1'b0;
            arr_sc    <= '0;
            dep_sc    <= '0;
            car_count <= '0;
            ovf       <= 1'b0;
            hold      <= '0;
            x         <= 1'b0;
        end else begin
            if (arr_raw == arr_f) begin
                arr_sc <= '0;
            end else if (arr_flip) begin
                arr_f  <= ~arr_f;
                arr_sc <= '0;
            end else begin
                arr_sc <= arr_sc + SC_W'(1);
            end

            if (dep_raw == dep_f) begin
                dep_sc <= '0;
            end else if (dep_flip) begin
                dep_f  <= ~dep_f;
                dep_sc <= '0;
            end else begin
                dep_sc <= dep_sc + SC_W'(1);
            end

            car_count <= cnt_n;
            ovf       <= ovf_n;
            hold      <= hold_n;
            x         <= (cnt_n != '0) || (hold_n != '0);
        end
    end

endmodule
